// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed from latched operands and committed when the countdown expires.
module mdu_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CW-1:0]      cnt, cnt_d;
    logic [WIDTH-1:0]   ra, rb, ra_d, rb_d;
    logic [1:0]         rop, rop_d;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic [WIDTH-1:0]   res_hi, res_lo;

    logic               sgn, na, nb;
    logic [2*WIDTH-1:0] ax, bx, prod;
    logic [WIDTH-1:0]   ma, mb, uq, ur;

    assign state = (cnt != '0) ? RUN : IDLE;
    assign busy  = (state == RUN);

    // Ops 0 and 2 are the signed flavours; bit 1 selects divide.
    always_comb begin
        sgn  = ~rop[0];
        ax   = {{WIDTH{sgn & ra[WIDTH-1]}}, ra};
        bx   = {{WIDTH{sgn & rb[WIDTH-1]}}, rb};
        prod = ax * bx;
        na   = sgn & ra[WIDTH-1];
        nb   = sgn & rb[WIDTH-1];
        ma   = na ? -ra : ra;
        mb   = nb ? -rb : rb;
        uq   = ma / mb;
        ur   = ma % mb;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (rop[1]) begin
            if (rb == '0) begin
                res_hi = ra;
                res_lo = '1;
            end else begin
                res_lo = (na ^ nb) ? -uq : uq;
                res_hi = na ? -ur : ur;
            end
        end
    end

    always_comb begin
        cnt_d = cnt;
        ra_d  = ra;
        rb_d  = rb;
        rop_d = rop;
        hi_d  = hi;
        lo_d  = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            ra_d  = a;
                            rb_d  = b;
                            rop_d = op[1:0];
                            cnt_d = CW'(MULT_LAT);
                        end
                        3'd2, 3'd3: begin
                            ra_d  = a;
                            rb_d  = b;
                            rop_d = op[1:0];
                            cnt_d = CW'(DIV_LAT);
                        end
                        3'd4: hi_d = a;
                        3'd5: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            ra  <= '0;
            rb  <= '0;
            rop <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            cnt <= cnt_d;
            ra  <= ra_d;
            rb  <= rb_d;
            rop <= rop_d;
            hi  <= hi_d;
            lo  <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed table, corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int tests = 0;
    int failed = 0;

    mdu_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l, output int lat);
        longint sa, sb, p, q, r;
        longint unsigned up;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        lat = 0;
        case (o)
            3'd0: begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
                lat = 5;
            end
            3'd1: begin
                up = {32'b0, x} * {32'b0, y};
                h = up[63:32];
                l = up[31:0];
                lat = 5;
            end
            3'd2, 3'd3: begin
                lat = 10;
                if (y == 0) begin
                    h = x;
                    l = 32'hFFFF_FFFF;
                end else if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
            3'd4: h = x;
            3'd5: l = x;
            default: ;
        endcase
    endfunction

    vec_t vecs[$];
    logic [31:0] mhi, mlo;
    int cyc, elat;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;

        vecs.push_back('{"mult_neg",   3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5});
        vecs.push_back('{"multu_max",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5});
        vecs.push_back('{"div_neg",    3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        vecs.push_back('{"divu_zero",  3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 10});
        vecs.push_back('{"div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 10});
        vecs.push_back('{"mthi",       3'd4, 32'h1234,      32'd7,         32'h1234,      32'h8000_0000, 0});
        vecs.push_back('{"mtlo",       3'd5, 32'h55,        32'd7,         32'h1234,      32'h55,        0});
        vecs.push_back('{"reserved6",  3'd6, 32'hAAAA,      32'hBBBB,      32'h1234,      32'h55,        0});
        vecs.push_back('{"div_zero_s", 3'd2, 32'hFFFF_FF00, 32'd0,         32'hFFFF_FF00, 32'hFFFF_FFFF, 10});
        vecs.push_back('{"divu_9_4",   3'd3, 32'd9,         32'd4,         32'd1,         32'd2,         10});

        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_hi", hi, 32'd0);
            check("rst_lo", lo, 32'd0);
        end

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check({vecs[i].name, "_lat"}, cyc, vecs[i].lat);
            check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
        end

        // MTLO while a DIV is in flight, with a/b also wiggling.
        run_op(3'd2, 32'd100, 32'd7, cyc);
        check("mtlo_mid_lat", cyc, 10);
        check("mtlo_mid_pre_lo", lo, 32'd14);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("div_idle_busy", {31'b0, busy}, 32'd1);
        @(negedge clk); @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'hDEAD; b = 32'd1;
        @(negedge clk);
        start = 1'b0; a = 32'd1; b = 32'd1;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("mtlo_mid_wait", {31'b0, busy}, 32'd0);
        check("mtlo_mid_lo", lo, 32'd16);
        check("mtlo_mid_hi", hi, 32'd2);

        // Start presented on the completion edge is dropped.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("cpl_busy_pre", {31'b0, busy}, 32'd1);
        start = 1'b1; op = 3'd4; a = 32'h5555;
        @(negedge clk);
        start = 1'b0;
        check("cpl_busy", {31'b0, busy}, 32'd0);
        check("cpl_lo", lo, 32'd12);
        check("cpl_hi", hi, 32'd0);
        @(negedge clk);
        check("cpl_hi_after", hi, 32'd0);
        run_op(3'd4, 32'h5555, 32'd0, cyc);
        check("cpl_next_mthi", hi, 32'h5555);

        // Reset during the third busy cycle abandons the MULT.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rmid_busy", {31'b0, busy}, 32'd0);
        check("rmid_hi", hi, 32'd0);
        check("rmid_lo", lo, 32'd0);
        repeat (6) @(negedge clk);
        check("rmid_lo_late", lo, 32'd0);
        run_op(3'd3, 32'd9, 32'd4, cyc);
        check("rmid_divu_lat", cyc, 10);
        check("rmid_divu_lo", lo, 32'd2);
        check("rmid_divu_hi", hi, 32'd1);

        // Randomized ops against the arithmetic model.
        do_reset();
        mhi = '0;
        mlo = '0;
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro;
            logic [31:0] rx, ry;
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 5) begin
                rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; ro = 3'd2;
            end
            model(ro, rx, ry, mhi, mlo, elat);
            run_op(ro, rx, ry, cyc);
            check("rand_lat", cyc, elat);
            check("rand_hi", hi, mhi);
            check("rand_lo", lo, mlo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
